// File: rtl/npu_axil_csr_slave.sv
// AXI4-Lite CSR slave for the NPU control path.
// Decodes control CPU reads/writes into a small register file and drives the
// datapath job descriptor (src/dst/len + one-cycle start pulse). Collects the
// datapath busy/done status into a sticky, interrupt-capable STATUS register.
//
// Ports:
//   clk, rst            single clock, synchronous active-high reset
//   s_axi_aw*/w*/b*     AXI4-Lite write channels (awprot ignored)
//   s_axi_ar*/r*        AXI4-Lite read channels (arprot ignored)
//   npu_start           one-cycle job start pulse
//   npu_src_addr/dst/len job descriptor registers
//   npu_busy, npu_done  datapath busy level and job-complete pulse
//   irq                 STATUS.DONE & CTRL.IRQ_EN, registered
//
// Register map (word index = addr[7:2]):
//   0x00 CTRL     bit0 START (W, reads 0), bit1 IRQ_EN (RW)
//   0x04 STATUS   bit0 BUSY (RO), bit1 DONE (sticky, W1C)
//   0x08 SRC_ADDR, 0x0C DST_ADDR, 0x10 LEN (RW, byte strobes)
//   0x14 VERSION  (RO)
//   other         SLVERR, reads 0
module npu_axil_csr_slave #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter logic [31:0] VERSION        = 32'h0001_0000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [2:0]                  s_axi_awprot,
  input  logic                        s_axi_awvalid,
  output logic                        s_axi_awready,
  input  logic [AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                        s_axi_wvalid,
  output logic                        s_axi_wready,
  output logic [1:0]                  s_axi_bresp,
  output logic                        s_axi_bvalid,
  input  logic                        s_axi_bready,
  input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [2:0]                  s_axi_arprot,
  input  logic                        s_axi_arvalid,
  output logic                        s_axi_arready,
  output logic [AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                  s_axi_rresp,
  output logic                        s_axi_rvalid,
  input  logic                        s_axi_rready,
  output logic                        npu_start,
  output logic [31:0]                 npu_src_addr,
  output logic [31:0]                 npu_dst_addr,
  output logic [31:0]                 npu_len,
  input  logic                        npu_busy,
  input  logic                        npu_done,
  output logic                        irq
);

  localparam logic [5:0] IdxCtrl   = 6'd0;
  localparam logic [5:0] IdxStatus = 6'd1;
  localparam logic [5:0] IdxSrc    = 6'd2;
  localparam logic [5:0] IdxDst    = 6'd3;
  localparam logic [5:0] IdxLen    = 6'd4;
  localparam logic [5:0] IdxVer    = 6'd5;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

  // Write holding registers
  logic        aw_held_q, aw_held_d;
  logic [5:0]  aw_idx_q, aw_idx_d;
  logic        w_held_q, w_held_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;

  // Response channels
  logic        bvalid_q, bvalid_d;
  logic [1:0]  bresp_q, bresp_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;

  // Register file
  logic        irq_en_q, irq_en_d;
  logic        done_q, done_d;
  logic [31:0] src_q, src_d;
  logic [31:0] dst_q, dst_d;
  logic [31:0] len_q, len_d;
  logic        start_q, start_d;
  logic        irq_q, irq_d;

  logic        aw_hs, w_hs, ar_hs, wr_fire;
  logic [5:0]  ar_idx;

  assign s_axi_awready = !aw_held_q && !bvalid_q && !rst;
  assign s_axi_wready  = !w_held_q && !bvalid_q && !rst;
  assign s_axi_arready = !rvalid_q && !rst;

  assign aw_hs   = s_axi_awvalid && s_axi_awready;
  assign w_hs    = s_axi_wvalid && s_axi_wready;
  assign ar_hs   = s_axi_arvalid && s_axi_arready;
  // Both halves present: commit on this edge, one write outstanding at a time.
  assign wr_fire = aw_held_q && w_held_q;
  assign ar_idx  = s_axi_araddr[7:2];

  // Only addr[7:2] is decoded; prot and remaining address bits are ignored.
  logic unused_ok;
  assign unused_ok = ^{s_axi_awprot, s_axi_arprot,
                       s_axi_awaddr[AXI_ADDR_WIDTH-1:8], s_axi_awaddr[1:0],
                       s_axi_araddr[AXI_ADDR_WIDTH-1:8], s_axi_araddr[1:0]};

  function automatic logic [31:0] merge_strb(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
    end
    return res;
  endfunction

  always_comb begin
    aw_held_d = aw_held_q;
    aw_idx_d  = aw_idx_q;
    w_held_d  = w_held_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    irq_en_d  = irq_en_q;
    done_d    = done_q;
    src_d     = src_q;
    dst_d     = dst_q;
    len_d     = len_q;
    start_d   = 1'b0;
    irq_d     = done_q && irq_en_q;

    if (aw_hs) begin
      aw_held_d = 1'b1;
      aw_idx_d  = s_axi_awaddr[7:2];
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      wdata_d  = s_axi_wdata;
      wstrb_d  = s_axi_wstrb;
    end

    if (wr_fire) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = RespOkay;
      case (aw_idx_q)
        IdxCtrl: begin
          if (wstrb_q[0]) begin
            irq_en_d = wdata_q[1];
            // A start request while the datapath is busy is silently dropped.
            start_d  = wdata_q[0] && !npu_busy;
          end
        end
        IdxStatus: begin
          if (wstrb_q[0] && wdata_q[1]) done_d = 1'b0;
        end
        IdxSrc:  src_d = merge_strb(src_q, wdata_q, wstrb_q);
        IdxDst:  dst_d = merge_strb(dst_q, wdata_q, wstrb_q);
        IdxLen:  len_d = merge_strb(len_q, wdata_q, wstrb_q);
        IdxVer:  ;
        default: bresp_d = RespSlvErr;
      endcase
    end else if (bvalid_q && s_axi_bready) begin
      bvalid_d = 1'b0;
    end

    // Set after the W1C so a coincident done pulse wins.
    if (npu_done) done_d = 1'b1;

    if (ar_hs) begin
      rvalid_d = 1'b1;
      rresp_d  = RespOkay;
      case (ar_idx)
        IdxCtrl:   rdata_d = {30'd0, irq_en_q, 1'b0};
        IdxStatus: rdata_d = {30'd0, done_q, npu_busy};
        IdxSrc:    rdata_d = src_q;
        IdxDst:    rdata_d = dst_q;
        IdxLen:    rdata_d = len_q;
        IdxVer:    rdata_d = VERSION;
        default: begin
          rdata_d = 32'd0;
          rresp_d = RespSlvErr;
        end
      endcase
    end else if (rvalid_q && s_axi_rready) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aw_held_q <= 1'b0;
      aw_idx_q  <= '0;
      w_held_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      irq_en_q  <= 1'b0;
      done_q    <= 1'b0;
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      start_q   <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      aw_held_q <= aw_held_d;
      aw_idx_q  <= aw_idx_d;
      w_held_q  <= w_held_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      irq_en_q  <= irq_en_d;
      done_q    <= done_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      len_q     <= len_d;
      start_q   <= start_d;
      irq_q     <= irq_d;
    end
  end

  assign s_axi_bvalid = bvalid_q;
  assign s_axi_bresp  = bresp_q;
  assign s_axi_rvalid = rvalid_q;
  assign s_axi_rdata  = rdata_q;
  assign s_axi_rresp  = rresp_q;
  assign npu_start    = start_q;
  assign npu_src_addr = src_q;
  assign npu_dst_addr = dst_q;
  assign npu_len      = len_q;
  assign irq          = irq_q;

endmodule
